// File: rtl/vga_reader_pkg.sv
// Shared types and helpers for the VGA frame reader: FSM state encoding and burst sizing.
package vga_reader_pkg;

    localparam int unsigned BURST_MAX      = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFstart = 3'd1,
        StSpace  = 3'd2,
        StIssue  = 3'd3,
        StRdata  = 3'd4,
        StFend   = 3'd5,
        StDrain  = 3'd6
    } state_e;

    function automatic int unsigned min_burst(input int unsigned rem, input int unsigned bmax);
        return (rem < bmax) ? rem : bmax;
    endfunction

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible whenever empty_o is low.
module vga_pixel_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned AW    = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      level_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [WIDTH-1:0] mem_q [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    // Level never exceeds Depth, so its MSB alone marks full.
    assign full_o  = level_q[AW];
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Avalon-MM burst frame reader with N-buffer rotation, streaming frame words to the pixel pipeline.
module vga_frame_reader
    import vga_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = BYTES_PER_WORD * 8,
    parameter int unsigned BURST_W = $clog2(BURST_MAX) + 1,
    parameter int unsigned FIFO_AW = 8,
    parameter int unsigned NUM_BUF = 2,
    parameter int unsigned WORDS_W = 20,
    localparam int unsigned BUF_W  = $clog2(NUM_BUF) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_enable,
    input  logic [NUM_BUF*ADDR_W-1:0] cfg_base_addr,
    input  logic [WORDS_W-1:0]        cfg_frame_words,
    input  logic [BUF_W-1:0]          latest_buf,
    input  logic                      cfg_clr_status,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_read,
    output logic [BURST_W-1:0]        avm_burstcount,
    input  logic                      avm_waitrequest,
    input  logic [DATA_W-1:0]         avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic [DATA_W-1:0]         pix_data,
    output logic                      pix_sof,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [2:0]                stat_state,
    output logic [FIFO_AW:0]          stat_level,
    output logic                      stat_underflow,
    output logic [BUF_W-1:0]          stat_cur_buf
);

    localparam int unsigned BurstMax  = 2 ** (BURST_W - 1);
    localparam int unsigned WordBytes = DATA_W / 8;

    state_e               state_q;
    logic [ADDR_W-1:0]    addr_q, avm_address_q;
    logic [WORDS_W-1:0]   remaining_q;
    logic [BURST_W-1:0]   beats_q, avm_burstcount_q;
    logic                 avm_read_q, sof_pending_q, underflow_q;
    logic [BUF_W-1:0]     cur_buf_q;

    logic [BURST_W-1:0]   blen;
    logic [FIFO_AW:0]     level, free;
    logic [BUF_W-1:0]     buf_sel;
    logic [ADDR_W-1:0]    base_sel;
    logic [WORDS_W-1:0]   rem_after;
    logic [DATA_W:0]      head;
    logic                 fifo_empty, fifo_full, push, pop, flush;

    always_comb begin
        blen      = BURST_W'(min_burst(32'(remaining_q), BurstMax));
        free      = {1'b1, {FIFO_AW{1'b0}}} - level;
        // An out-of-range writer index keeps reading the current buffer.
        buf_sel   = (32'(latest_buf) < NUM_BUF) ? latest_buf : cur_buf_q;
        base_sel  = cfg_base_addr[32'(buf_sel) * ADDR_W +: ADDR_W];
        rem_after = remaining_q - WORDS_W'(avm_burstcount_q);
        push      = (state_q == StRdata) && avm_readdatavalid;
        pop       = pix_ready;
        flush     = (state_q == StDrain);
    end

    vga_pixel_fifo #(
        .WIDTH(DATA_W + 1),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk_i  (clk),
        .reset_i(reset),
        .flush_i(flush),
        .push_i (push),
        .wdata_i({sof_pending_q, avm_readdata}),
        .pop_i  (pop),
        .rdata_o(head),
        .level_o(level),
        .empty_o(fifo_empty),
        .full_o (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            avm_address_q    <= '0;
            avm_burstcount_q <= '0;
            avm_read_q       <= 1'b0;
            remaining_q      <= '0;
            beats_q          <= '0;
            sof_pending_q    <= 1'b0;
            underflow_q      <= 1'b0;
            cur_buf_q        <= '0;
        end else begin
            if (pix_ready && fifo_empty && state_q != StIdle) begin
                underflow_q <= 1'b1;
            end else if (cfg_clr_status) begin
                underflow_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (cfg_enable) state_q <= StFstart;
                end
                StFstart: begin
                    cur_buf_q     <= buf_sel;
                    addr_q        <= base_sel;
                    remaining_q   <= (cfg_frame_words == '0) ? WORDS_W'(1) : cfg_frame_words;
                    sof_pending_q <= 1'b1;
                    state_q       <= StSpace;
                end
                StSpace: begin
                    // Reserve room for the whole burst so the FIFO can never overflow.
                    if (32'(free) >= 32'(blen)) begin
                        avm_read_q       <= 1'b1;
                        avm_address_q    <= addr_q;
                        avm_burstcount_q <= blen;
                        state_q          <= StIssue;
                    end
                end
                StIssue: begin
                    if (!avm_waitrequest) begin
                        avm_read_q <= 1'b0;
                        addr_q     <= addr_q + ADDR_W'(32'(avm_burstcount_q) * WordBytes);
                        beats_q    <= avm_burstcount_q;
                        state_q    <= StRdata;
                    end
                end
                StRdata: begin
                    if (avm_readdatavalid) begin
                        sof_pending_q <= 1'b0;
                        beats_q       <= beats_q - BURST_W'(1);
                        if (beats_q == BURST_W'(1)) begin
                            remaining_q <= rem_after;
                            if (!cfg_enable)           state_q <= StDrain;
                            else if (rem_after == '0)  state_q <= StFend;
                            else                       state_q <= StSpace;
                        end
                    end
                end
                StFend: begin
                    state_q <= cfg_enable ? StFstart : StDrain;
                end
                StDrain: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full && !pop));
        end
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_burstcount = avm_burstcount_q;
    assign pix_valid      = ~fifo_empty;
    assign pix_data       = fifo_empty ? '0 : head[DATA_W-1:0];
    assign pix_sof        = ~fifo_empty & head[DATA_W];
    assign stat_state     = state_q;
    assign stat_level     = level;
    assign stat_underflow = underflow_q;
    assign stat_cur_buf   = cur_buf_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader with a burst-capable Avalon slave and a pixel consumer.
module tb_vga_frame_reader;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 6;
    localparam int unsigned FA = 6;
    localparam int unsigned NB = 3;
    localparam int unsigned WW = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_enable = 1'b0;
    logic             cfg_clr_status = 1'b0;
    logic [NB*AW-1:0] cfg_base_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
    logic [WW-1:0]    cfg_frame_words = 20'd100;
    logic [2:0]       latest_buf = 3'd0;
    logic [AW-1:0]    avm_address;
    logic             avm_read;
    logic [BW-1:0]    avm_burstcount;
    logic             avm_waitrequest = 1'b0;
    logic [DW-1:0]    avm_readdata = '0;
    logic             avm_readdatavalid = 1'b0;
    logic [DW-1:0]    pix_data;
    logic             pix_sof, pix_valid;
    logic             pix_ready = 1'b0;
    logic [2:0]       stat_state;
    logic [FA:0]      stat_level;
    logic             stat_underflow;
    logic [2:0]       stat_cur_buf;

    int checks = 0;
    int errors = 0;

    // Slave model state.
    int          stall_left = 0;
    int          stall_seen = 0;
    logic        stall_bad = 1'b0;
    logic [31:0] stall_addr = '0;
    logic [5:0]  stall_bc = '0;
    int          pending = 0;
    int          gap_cnt = 0;
    int          rdv_gap = 0;
    logic [31:0] beat_addr = '0;
    logic [31:0] b_addr[$];
    int          b_len[$];

    // Consumer model state.
    bit          ready_en = 1'b0;
    logic [31:0] pop_data[$];
    logic        pop_sof[$];
    bit          saw_drain = 1'b0;

    always #5 clk = ~clk;

    vga_frame_reader #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .BURST_W(BW),
        .FIFO_AW(FA),
        .NUM_BUF(NB),
        .WORDS_W(WW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_enable       (cfg_enable),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_frame_words  (cfg_frame_words),
        .latest_buf       (latest_buf),
        .cfg_clr_status   (cfg_clr_status),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_burstcount   (avm_burstcount),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .pix_data         (pix_data),
        .pix_sof          (pix_sof),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .stat_state       (stat_state),
        .stat_level       (stat_level),
        .stat_underflow   (stat_underflow),
        .stat_cur_buf     (stat_cur_buf)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Slave decisions are made on the falling edge and take effect at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            pending           = 0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
        end else begin
            avm_readdatavalid = 1'b0;
            if (pending > 0) begin
                if (gap_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = word_at(beat_addr);
                    beat_addr         = beat_addr + 32'd4;
                    pending           = pending - 1;
                    gap_cnt           = rdv_gap;
                end else begin
                    gap_cnt = gap_cnt - 1;
                end
            end
            if (avm_read) begin
                if (stall_seen == 0) begin
                    stall_addr = avm_address;
                    stall_bc   = avm_burstcount;
                end else if (avm_address !== stall_addr || avm_burstcount !== stall_bc) begin
                    stall_bad = 1'b1;
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left      = stall_left - 1;
                    stall_seen      = stall_seen + 1;
                end else begin
                    avm_waitrequest = 1'b0;
                    b_addr.push_back(avm_address);
                    b_len.push_back(int'(avm_burstcount));
                    pending   = int'(avm_burstcount);
                    beat_addr = avm_address;
                    gap_cnt   = 0;
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        pix_ready = ready_en;
        if (!reset && pix_valid && pix_ready) begin
            pop_data.push_back(pix_data);
            pop_sof.push_back(pix_sof);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (stat_state == 3'd6) saw_drain = 1'b1;
        end
    endtask

    task automatic wait_bursts(input int n, input int bound, input string tag);
        int i = 0;
        while (b_addr.size() < n && i < bound) begin
            tick(1);
            i++;
        end
        check(tag, 64'(b_addr.size() >= n), 64'd1);
    endtask

    task automatic wait_pops(input int n, input int bound, input string tag);
        int i = 0;
        while (pop_data.size() < n && i < bound) begin
            tick(1);
            i++;
        end
        check(tag, 64'(pop_data.size() >= n), 64'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
        int i = 0;
        while (stat_state !== s && i < bound) begin
            tick(1);
            i++;
        end
        check(tag, 64'(stat_state), 64'(s));
    endtask

    task automatic wait_level(input int l, input int bound, input string tag);
        int i = 0;
        while (int'(stat_level) != l && i < bound) begin
            tick(1);
            i++;
        end
        check(tag, 64'(stat_level), 64'(l));
    endtask

    task automatic wait_uf(input int bound, input string tag);
        int i = 0;
        while (stat_underflow !== 1'b1 && i < bound) begin
            tick(1);
            i++;
        end
        check(tag, 64'(stat_underflow), 64'd1);
    endtask

    initial begin
        int bad_d;
        int bad_s;
        int n0;

        // Reset values.
        tick(3);
        check("rst_state", 64'(stat_state), 64'd0);
        check("rst_read", 64'(avm_read), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_bc", 64'(avm_burstcount), 64'd0);
        check("rst_valid", 64'(pix_valid), 64'd0);
        check("rst_sof", 64'(pix_sof), 64'd0);
        check("rst_level", 64'(stat_level), 64'd0);
        check("rst_uf", 64'(stat_underflow), 64'd0);
        check("rst_curbuf", 64'(stat_cur_buf), 64'd0);
        reset = 1'b0;

        // 100-word frame: 32/32/32/4 bursts; buffer switch takes effect only at next frame.
        ready_en   = 1'b1;
        cfg_enable = 1'b1;
        wait_bursts(1, 100, "b1_first_burst");
        latest_buf = 3'd2;
        check("b1_curbuf_held", 64'(stat_cur_buf), 64'd0);
        wait_bursts(4, 400, "b1_four_bursts");
        check("b1_addr0", 64'(b_addr[0]), 64'h1000_0000);
        check("b1_len0", 64'(b_len[0]), 64'd32);
        check("b1_addr1", 64'(b_addr[1]), 64'h1000_0080);
        check("b1_len1", 64'(b_len[1]), 64'd32);
        check("b1_addr2", 64'(b_addr[2]), 64'h1000_0100);
        check("b1_len2", 64'(b_len[2]), 64'd32);
        check("b1_addr3", 64'(b_addr[3]), 64'h1000_0180);
        check("b1_len3", 64'(b_len[3]), 64'd4);
        wait_bursts(5, 400, "b3_next_frame");
        check("b3_addr", 64'(b_addr[4]), 64'h3000_0000);
        check("b3_curbuf", 64'(stat_cur_buf), 64'd2);
        wait_pops(101, 800, "b1_pops");
        bad_d = 0;
        bad_s = 0;
        for (int i = 0; i < 100; i++) begin
            if (pop_data[i] !== word_at(32'h1000_0000 + 32'(4 * i))) bad_d++;
            if (pop_sof[i] !== (i == 0)) bad_s++;
        end
        check("b1_data_bad", 64'(bad_d), 64'd0);
        check("b1_sof_bad", 64'(bad_s), 64'd0);
        check("b3_word0", 64'(pop_data[100]), 64'(word_at(32'h3000_0000)));
        check("b3_sof0", 64'(pop_sof[100]), 64'd1);
        cfg_enable = 1'b0;
        wait_state(3'd0, 800, "b1_idle");
        check("b1_idle_valid", 64'(pix_valid), 64'd0);
        check("b1_idle_level", 64'(stat_level), 64'd0);

        // Waitrequest stall, then backpressure filling the 64-deep FIFO.
        n0              = b_addr.size();
        stall_seen      = 0;
        stall_bad       = 1'b0;
        stall_left      = 5;
        ready_en        = 1'b0;
        cfg_frame_words = 20'd1000;
        cfg_enable      = 1'b1;
        wait_bursts(n0 + 1, 100, "b2_accept");
        check("b2_addr", 64'(b_addr[n0]), 64'h3000_0000);
        check("b2_len", 64'(b_len[n0]), 64'd32);
        check("b2_stall_cycles", 64'(stall_seen), 64'd5);
        check("b2_stable", 64'(stall_bad), 64'd0);
        tick(3);
        check("b2_one_burst", 64'(b_addr.size()), 64'(n0 + 1));
        wait_level(64, 300, "b4_level64");
        tick(1);
        check("b4_state_space", 64'(stat_state), 64'd2);
        check("b4_no_read", 64'(avm_read), 64'd0);
        check("b4_bursts", 64'(b_addr.size()), 64'(n0 + 2));
        check("b4_addr1", 64'(b_addr[n0 + 1]), 64'h3000_0080);
        tick(10);
        check("b4_level_hold", 64'(stat_level), 64'd64);
        check("b4_still_two", 64'(b_addr.size()), 64'(n0 + 2));
        ready_en = 1'b1;
        wait_bursts(n0 + 3, 200, "b4_resume");
        check("b4_addr2", 64'(b_addr[n0 + 2]), 64'h3000_0100);

        // Underflow: clear, provoke with slow read data, sticky, clear again.
        ready_en = 1'b0;
        tick(2);
        cfg_clr_status = 1'b1;
        tick(1);
        cfg_clr_status = 1'b0;
        check("b5_cleared", 64'(stat_underflow), 64'd0);
        rdv_gap  = 3;
        ready_en = 1'b1;
        wait_uf(400, "b5_set");
        ready_en = 1'b0;
        tick(5);
        check("b5_sticky", 64'(stat_underflow), 64'd1);
        cfg_clr_status = 1'b1;
        tick(1);
        cfg_clr_status = 1'b0;
        check("b5_clr", 64'(stat_underflow), 64'd0);

        // Disable mid-burst: burst completes, then drain to idle.
        ready_en = 1'b1;
        wait_state(3'd4, 600, "b6_rdata");
        cfg_enable = 1'b0;
        n0         = b_addr.size();
        saw_drain  = 1'b0;
        wait_state(3'd0, 1000, "b6_idle");
        check("b6_no_new_burst", 64'(b_addr.size()), 64'(n0));
        check("b6_all_beats", 64'(pending), 64'd0);
        check("b6_drained", 64'(saw_drain), 64'd1);
        check("b6_valid", 64'(pix_valid), 64'd0);
        check("b6_level", 64'(stat_level), 64'd0);

        // Reset mid-burst.
        rdv_gap    = 0;
        cfg_enable = 1'b1;
        wait_state(3'd4, 600, "b6r_rdata");
        tick(3);
        reset      = 1'b1;
        cfg_enable = 1'b0;
        tick(1);
        reset = 1'b0;
        check("b6r_state", 64'(stat_state), 64'd0);
        check("b6r_read", 64'(avm_read), 64'd0);
        check("b6r_valid", 64'(pix_valid), 64'd0);
        check("b6r_level", 64'(stat_level), 64'd0);
        check("b6r_uf", 64'(stat_underflow), 64'd0);
        check("b6r_bc", 64'(avm_burstcount), 64'd0);
        check("b6r_addr", 64'(avm_address), 64'd0);
        tick(4);
        check("b6r_stay_idle", 64'(stat_state), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
